// File: rtl/text_pkg.sv
// Shared constants, control codes and state/command encodings for the text
// display writer and its test benches.
package text_pkg;

  localparam int COLS         = 70;
  localparam int ROWS         = 30;
  localparam int SCREEN_CELLS = COLS * ROWS;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_FF = 8'h0C;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR_ROW,
    CLEAR_ALL
  } writer_state_t;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_INC,
    CUR_DEC,
    CUR_NEWLINE,
    CUR_HOME
  } cursor_cmd_t;

endpackage

// File: rtl/text_cursor.sv
// Row/column cursor with a running row base, so the linear address never
// needs a multiply, divide or modulo.
module text_cursor #(
  parameter int COLS   = text_pkg::COLS,
  parameter int ROWS   = text_pkg::ROWS,
  parameter int ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  text_pkg::cursor_cmd_t cmd,
  output logic [ADDR_W-1:0]     cursor,
  output logic [ADDR_W-1:0]     row_base,
  output logic                  at_eol,
  output logic                  last_row,
  output logic                  at_home
);
  import text_pkg::*;

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] next_base;

  assign at_eol    = (col == CW'(COLS - 1));
  assign last_row  = (row == RW'(ROWS - 1));
  assign at_home   = (cursor == '0);
  assign next_base = last_row ? '0 : row_base + ADDR_W'(COLS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      cursor   <= '0;
    end else begin
      case (cmd)
        CUR_INC: begin
          if (at_eol) begin
            col      <= '0;
            row      <= last_row ? '0 : row + RW'(1);
            row_base <= next_base;
            cursor   <= next_base;
          end else begin
            col    <= col + CW'(1);
            cursor <= cursor + ADDR_W'(1);
          end
        end
        CUR_NEWLINE: begin
          col      <= '0;
          row      <= last_row ? '0 : row + RW'(1);
          row_base <= next_base;
          cursor   <= next_base;
        end
        CUR_DEC: begin
          // Stepping back over a row boundary lands on base-1, the previous row's last cell.
          if (col != '0) begin
            col    <= col - CW'(1);
            cursor <= cursor - ADDR_W'(1);
          end else if (row != '0) begin
            row      <= row - RW'(1);
            col      <= CW'(COLS - 1);
            row_base <= row_base - ADDR_W'(COLS);
            cursor   <= cursor - ADDR_W'(1);
          end
        end
        CUR_HOME: begin
          col      <= '0;
          row      <= '0;
          row_base <= '0;
          cursor   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/text_writer.sv
// Keyboard-side writer: consumes ASCII codes and drives the character RAM
// write port, handling CR, BS, FF, line wrap and row clearing.
module text_writer #(
  parameter int COLS   = text_pkg::COLS,
  parameter int ROWS   = text_pkg::ROWS,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ascii_valid,
  input  logic [7:0]        ascii,
  output logic              ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] cursor
);
  import text_pkg::*;

  localparam int CW    = $clog2(COLS);
  localparam int CELLS = COLS * ROWS;

  writer_state_t     state, next_state;
  cursor_cmd_t       cmd;
  logic [ADDR_W-1:0] row_base, next_base;
  logic              at_eol, last_row, at_home;
  logic              printable, bs_write;
  logic [CW-1:0]     clr_cnt, clr_cnt_d;
  logic              wrap_q, wrap_d, bs_q, bs_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [7:0]        wr_data_d;

  text_cursor #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cursor (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd      (cmd),
    .cursor   (cursor),
    .row_base (row_base),
    .at_eol   (at_eol),
    .last_row (last_row),
    .at_home  (at_home)
  );

  assign ready     = (state == IDLE);
  assign printable = (ascii >= ASCII_SP) && (ascii <= 8'h7E);
  assign bs_write  = (ascii == ASCII_BS) && !at_home;
  assign next_base = last_row ? '0 : row_base + ADDR_W'(COLS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (ascii_valid) begin
          if (printable || bs_write)    next_state = WRITE;
          else if (ascii == ASCII_CR)   next_state = CLEAR_ROW;
          else if (ascii == ASCII_FF)   next_state = CLEAR_ALL;
        end
      end
      WRITE:     next_state = wrap_q ? CLEAR_ROW : IDLE;
      CLEAR_ROW: if (clr_cnt == CW'(COLS - 1)) next_state = IDLE;
      CLEAR_ALL: if (wr_addr == ADDR_W'(CELLS - 1)) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // The cursor moves only when the operation's final write retires, so a
  // wrapping character holds the cursor until its new row is fully cleared.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    clr_cnt_d = clr_cnt;
    wrap_d    = wrap_q;
    bs_d      = bs_q;
    cmd       = CUR_NONE;
    case (state)
      IDLE: begin
        if (ascii_valid) begin
          if (printable) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cursor;
            wr_data_d = ascii;
            wrap_d    = at_eol;
            bs_d      = 1'b0;
          end else if (ascii == ASCII_CR) begin
            wr_en_d   = 1'b1;
            wr_addr_d = next_base;
            wr_data_d = ASCII_SP;
            clr_cnt_d = '0;
          end else if (ascii == ASCII_FF) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = ASCII_SP;
          end else if (bs_write) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cursor - ADDR_W'(1);
            wr_data_d = ASCII_SP;
            wrap_d    = 1'b0;
            bs_d      = 1'b1;
          end
        end
      end
      WRITE: begin
        if (wrap_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = next_base;
          wr_data_d = ASCII_SP;
          clr_cnt_d = '0;
        end else begin
          cmd = bs_q ? CUR_DEC : CUR_INC;
        end
      end
      CLEAR_ROW: begin
        if (clr_cnt == CW'(COLS - 1)) begin
          cmd = CUR_NEWLINE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr + ADDR_W'(1);
          clr_cnt_d = clr_cnt + CW'(1);
        end
      end
      CLEAR_ALL: begin
        if (wr_addr == ADDR_W'(CELLS - 1)) begin
          cmd = CUR_HOME;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      clr_cnt <= '0;
      wrap_q  <= 1'b0;
      bs_q    <= 1'b0;
    end else begin
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      clr_cnt <= clr_cnt_d;
      wrap_q  <= wrap_d;
      bs_q    <= bs_d;
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// Bench for text_writer: a row/col screen model predicts every write, the
// busy time and the cursor; directed scenarios pin key values as literals.
module tb_text_writer;
  import text_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ascii_valid = 1'b0;
  logic [7:0]  ascii = 8'h00;
  logic        ready, wr_en;
  logic [11:0] wr_addr, cursor;
  logic [7:0]  wr_data;

  text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(12)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ascii_valid (ascii_valid),
    .ascii       (ascii),
    .ready       (ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .cursor      (cursor)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int m_row = 0, m_col = 0, m_busy = 0, m_prev = 0;
  int q_addr[$];
  int q_data[$];

  int n_wr = 0, first_addr = -1, last_addr = -1, last_data = -1, low_cycles = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic push_row(input int r);
    for (int i = 0; i < COLS; i++) begin
      q_addr.push_back(r * COLS + i);
      q_data.push_back(32'h20);
    end
  endtask

  task automatic model_accept(input logic [7:0] c);
    m_prev = m_row * COLS + m_col;
    if (c >= 8'h20 && c <= 8'h7E) begin
      q_addr.push_back(m_prev);
      q_data.push_back(int'(c));
      m_busy = 1;
      if (m_col == COLS - 1) begin
        m_row = (m_row + 1) % ROWS;
        m_col = 0;
        push_row(m_row);
        m_busy += COLS;
      end else begin
        m_col++;
      end
    end else if (c == ASCII_CR) begin
      m_row = (m_row + 1) % ROWS;
      m_col = 0;
      push_row(m_row);
      m_busy = COLS;
    end else if (c == ASCII_BS) begin
      if (m_col > 0 || m_row > 0) begin
        if (m_col > 0) m_col--;
        else begin
          m_row--;
          m_col = COLS - 1;
        end
        q_addr.push_back(m_row * COLS + m_col);
        q_data.push_back(32'h20);
        m_busy = 1;
      end
    end else if (c == ASCII_FF) begin
      for (int i = 0; i < SCREEN_CELLS; i++) begin
        q_addr.push_back(i);
        q_data.push_back(32'h20);
      end
      m_row  = 0;
      m_col  = 0;
      m_busy = SCREEN_CELLS;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      m_row = 0; m_col = 0; m_busy = 0; m_prev = 0;
      q_addr.delete();
      q_data.delete();
    end else begin
      if (m_busy > 0) m_busy--;
      else if (ascii_valid) model_accept(ascii);
      chk("ready", int'(ready), int'(m_busy == 0));
      chk("wr_en", int'(wr_en), int'(m_busy > 0));
      if (wr_en) begin
        chk("wr_expected", int'(q_addr.size() > 0), 1);
        if (q_addr.size() > 0) begin
          chk("wr_addr", int'(wr_addr), q_addr.pop_front());
          chk("wr_data", int'(wr_data), q_data.pop_front());
        end
      end
      if (m_busy == 0) chk("writes_left", q_addr.size(), 0);
      chk("cursor", int'(cursor), (m_busy == 0) ? m_row * COLS + m_col : m_prev);
      if (!ready) low_cycles++;
      if (wr_en) begin
        if (n_wr == 0) first_addr = int'(wr_addr);
        last_addr = int'(wr_addr);
        last_data = int'(wr_data);
        n_wr++;
      end
    end
  end

  task automatic clear_stats();
    n_wr = 0; first_addr = -1; last_addr = -1; last_data = -1; low_cycles = 0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ready && m_busy == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_wait", int'(ok), 1);
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    ascii       = c;
    ascii_valid = 1'b1;
    @(negedge clk);
    ascii_valid = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] c);
    wait_idle();
    send(c);
    wait_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_cursor", int'(cursor), 0);

    // single printable
    clear_stats();
    send_op(8'h41);
    chk("a_writes", n_wr, 1);
    chk("a_addr", first_addr, 0);
    chk("a_data", last_data, 32'h41);
    chk("a_cursor", int'(cursor), 1);
    chk("a_low", low_cycles, 1);

    // 70 printables from reset: line wrap clears row 1
    do_reset();
    for (int i = 0; i < COLS - 1; i++) send_op(8'h41 + 8'(i % 26));
    clear_stats();
    send_op(8'h5A);
    chk("wrap_writes", n_wr, 71);
    chk("wrap_first", first_addr, 69);
    chk("wrap_last", last_addr, 139);
    chk("wrap_low", low_cycles, 71);
    chk("wrap_cursor", int'(cursor), 70);

    // backspace across the row boundary, then rewrap
    clear_stats();
    send_op(ASCII_BS);
    chk("bs_row_addr", last_addr, 69);
    chk("bs_row_data", last_data, 32'h20);
    chk("bs_row_cursor", int'(cursor), 69);
    send_op(8'h78);
    chk("rewrap_cursor", int'(cursor), 70);

    // boundary codes: 0x1F and 0x7F ignored, 0x7E printable
    clear_stats();
    send_op(8'h1F);
    send_op(8'h7F);
    chk("ign_writes", n_wr, 0);
    chk("ign_low", low_cycles, 0);
    send_op(8'h7E);
    send_op(8'h41);
    chk("c72_cursor", int'(cursor), 72);
    clear_stats();
    send_op(ASCII_BS);
    chk("bs_addr", last_addr, 71);
    chk("bs_cursor", int'(cursor), 71);
    chk("bs_low", low_cycles, 1);

    // backspace at home is a no-op
    do_reset();
    clear_stats();
    send_op(ASCII_BS);
    chk("bs0_writes", n_wr, 0);
    chk("bs0_low", low_cycles, 0);
    chk("bs0_cursor", int'(cursor), 0);

    // CR from row 29 col 5 wraps to row 0
    for (int i = 0; i < ROWS - 1; i++) send_op(ASCII_CR);
    for (int i = 0; i < 5; i++) send_op(8'h30 + 8'(i));
    chk("r29_cursor", int'(cursor), 2035);
    clear_stats();
    send_op(ASCII_CR);
    chk("cr_writes", n_wr, 70);
    chk("cr_first", first_addr, 0);
    chk("cr_last", last_addr, 69);
    chk("cr_low", low_cycles, 70);
    chk("cr_cursor", int'(cursor), 0);

    // form feed clears the whole screen
    for (int i = 0; i < 3; i++) send_op(8'h61 + 8'(i));
    clear_stats();
    send_op(ASCII_FF);
    chk("ff_writes", n_wr, 2100);
    chk("ff_first", first_addr, 0);
    chk("ff_last", last_addr, 2099);
    chk("ff_low", low_cycles, 2100);
    chk("ff_cursor", int'(cursor), 0);
    chk("ff_ready", int'(ready), 1);

    // reset during a row clear at its 10th write
    wait_idle();
    clear_stats();
    send(ASCII_CR);
    repeat (9) @(negedge clk);
    chk("mid_writes", n_wr, 10);
    chk("mid_addr", last_addr, 79);
    reset_n = 1'b0;
    #1;
    chk("mid_wr_en", int'(wr_en), 0);
    chk("mid_cursor", int'(cursor), 0);
    chk("mid_ready", int'(ready), 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_stats();
    send_op(8'h07);
    repeat (3) @(negedge clk);
    chk("bel_writes", n_wr, 0);
    chk("bel_cursor", int'(cursor), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
